// File: rtl/level_pkg.sv
// Shared constants for the level memory: default geometry and wrap-mode encodings.
package level_pkg;

  localparam int unsigned DEF_WIDTH  = 4;
  localparam int unsigned DEF_LV_MIN = 1;
  localparam int unsigned DEF_LV_MAX = (2 ** DEF_WIDTH) - 1;

  typedef enum int unsigned {
    WRAP_SAT  = 0,
    WRAP_ROLL = 1
  } wrap_mode_e;

endpackage

// File: rtl/level_mem_param_edge_det.sv
// Rising-edge detector for a level-type button. History resets to 1 so a
// button held through reset never yields an event.
module edge_det (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic rise
);

  logic hist_q;
  logic hist_d;

  // Next history is the current button level; event is 1 now, 0 last cycle.
  always_comb begin
    hist_d = sig_in;
    rise   = sig_in & ~hist_q;
  end

  // History register, asynchronously preset on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist_q <= 1'b1;
    else       hist_q <= hist_d;
  end

endmodule

// File: rtl/level_mem_param.sv
// Level memory: a bounded level register stepped by up/down button edges,
// with clear, restart and load overrides and registered status pulses.
module level_mem_param
  import level_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned LV_MIN = DEF_LV_MIN,
  parameter int unsigned LV_MAX = (2 ** WIDTH) - 1,
  parameter int unsigned WRAP   = WRAP_SAT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             restart,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             up,
  input  logic             down,
  output logic [WIDTH-1:0] level,
  output logic             at_max,
  output logic             at_min,
  output logic             changed,
  output logic             limit_hit
);

  generate
    if (LV_MIN < 1 || LV_MIN >= LV_MAX || LV_MAX > (2 ** WIDTH) - 1 ||
        WRAP > int'(WRAP_ROLL)) begin : g_bad_params
      $error("level_mem_param: illegal WIDTH/LV_MIN/LV_MAX/WRAP combination");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MIN_L = WIDTH'(LV_MIN);
  localparam logic [WIDTH-1:0] MAX_L = WIDTH'(LV_MAX);
  localparam logic [WIDTH-1:0] ONE_L = WIDTH'(1);
  localparam bit               ROLL  = (WRAP == int'(WRAP_ROLL));

  logic             up_ev;
  logic             dn_ev;
  logic [WIDTH-1:0] level_q, level_d;
  logic             changed_q, changed_d;
  logic             limit_q, limit_d;

  edge_det u_up_det (
    .clk    (clk),
    .reset  (reset),
    .sig_in (up),
    .rise   (up_ev)
  );

  edge_det u_dn_det (
    .clk    (clk),
    .reset  (reset),
    .sig_in (down),
    .rise   (dn_ev)
  );

  // Next level by priority clear > restart > load > button events; simultaneous
  // up and down events cancel.
  always_comb begin
    level_d = level_q;
    limit_d = 1'b0;
    if (clear) begin
      level_d = '0;
    end else if (restart) begin
      level_d = MIN_L;
    end else if (load) begin
      if (load_val == '0)       level_d = '0;
      else if (load_val < MIN_L) level_d = MIN_L;
      else if (load_val > MAX_L) level_d = MAX_L;
      else                       level_d = load_val;
    end else if (up_ev && !dn_ev) begin
      if (level_q == '0) begin
        level_d = MIN_L;
      end else if (level_q == MAX_L) begin
        limit_d = 1'b1;
        if (ROLL) level_d = MIN_L;
      end else begin
        level_d = level_q + ONE_L;
      end
    end else if (dn_ev && !up_ev) begin
      if (level_q == '0) begin
        level_d = level_q;
      end else if (level_q == MIN_L) begin
        limit_d = 1'b1;
        if (ROLL) level_d = MAX_L;
      end else begin
        level_d = level_q - ONE_L;
      end
    end
    changed_d = (level_d != level_q);
  end

  // Level and status registers, asynchronously reset to LV_MIN / idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q   <= MIN_L;
      changed_q <= 1'b0;
      limit_q   <= 1'b0;
    end else begin
      level_q   <= level_d;
      changed_q <= changed_d;
      limit_q   <= limit_d;
    end
  end

  // Outputs: status decodes of the level register and the registered pulses.
  always_comb begin
    level     = level_q;
    at_max    = (level_q == MAX_L);
    at_min    = (level_q == MIN_L);
    changed   = changed_q;
    limit_hit = limit_q;
  end

endmodule

// File: tb/tb_level_mem_param.sv
// Bench for level_mem_param: a saturating and a wrapping instance share all
// inputs; expected results are queued with each stimulus and checked on output.
module tb_level_mem_param;

  logic       clk = 1'b0;
  logic       reset, clear, restart, load, up, down;
  logic [3:0] load_val;
  logic [3:0] lvl0, lvl1;
  logic       amax0, amin0, chg0, lim0;
  logic       amax1, amin1, chg1, lim1;

  int n_cmp = 0;
  int n_bad = 0;
  int chg_cnt = 0;

  typedef struct {
    string      tag;
    logic [3:0] l0, l1;
    logic       c0, c1, h0, h1;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  level_mem_param #(.WIDTH(4), .LV_MIN(1), .LV_MAX(15), .WRAP(0)) dut_sat (
    .clk(clk), .reset(reset), .clear(clear), .restart(restart), .load(load),
    .load_val(load_val), .up(up), .down(down), .level(lvl0), .at_max(amax0),
    .at_min(amin0), .changed(chg0), .limit_hit(lim0)
  );

  level_mem_param #(.WIDTH(4), .LV_MIN(1), .LV_MAX(15), .WRAP(1)) dut_wrap (
    .clk(clk), .reset(reset), .clear(clear), .restart(restart), .load(load),
    .load_val(load_val), .up(up), .down(down), .level(lvl1), .at_max(amax1),
    .at_min(amin1), .changed(chg1), .limit_hit(lim1)
  );

  always @(negedge clk) if (chg0 === 1'b1) chg_cnt++;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [3:0] l0, input logic [3:0] l1,
                      input logic c0, input logic c1, input logic h0, input logic h1);
    exp_t e;
    e.tag = tag; e.l0 = l0; e.l1 = l1; e.c0 = c0; e.c1 = c1; e.h0 = h0; e.h1 = h1;
    sb.push_back(e);
  endtask

  task automatic check_next();
    exp_t e;
    e = sb.pop_front();
    chk({e.tag, ".level_sat"},   {4'h0, lvl0}, {4'h0, e.l0});
    chk({e.tag, ".level_wrap"},  {4'h0, lvl1}, {4'h0, e.l1});
    chk({e.tag, ".changed_sat"},  {7'h0, chg0}, {7'h0, e.c0});
    chk({e.tag, ".changed_wrap"}, {7'h0, chg1}, {7'h0, e.c1});
    chk({e.tag, ".limit_sat"},    {7'h0, lim0}, {7'h0, e.h0});
    chk({e.tag, ".limit_wrap"},   {7'h0, lim1}, {7'h0, e.h1});
  endtask

  task automatic expect_now(input string tag, input logic [3:0] l0, input logic [3:0] l1,
                            input logic c0, input logic c1, input logic h0, input logic h1);
    push(tag, l0, l1, c0, c1, h0, h1);
    check_next();
  endtask

  task automatic press_up();
    up = 1'b1; tick(); up = 1'b0;
  endtask

  task automatic press_dn();
    down = 1'b1; tick(); down = 1'b0;
  endtask

  task automatic do_load(input logic [3:0] v);
    load = 1'b1; load_val = v; tick(); load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; restart = 1'b0; load = 1'b0;
    up = 1'b0; down = 1'b0; load_val = '0;

    repeat (2) tick();
    expect_now("rst_hold", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_at_min", {7'h0, amin0}, 8'h1);
    chk("rst_at_max", {7'h0, amax0}, 8'h0);
    reset = 1'b0;
    tick();
    expect_now("rst_rel", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int unsigned i = 0; i < 5; i++) begin
      press_up();
      expect_now("up_step", 4'(i + 2), 4'(i + 2), 1'b1, 1'b1, 1'b0, 1'b0);
      tick();
    end
    expect_now("up_settle", 4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("changed_count", 8'(chg_cnt), 8'd5);

    do_load(4'd15);
    expect_now("load15", 4'd15, 4'd15, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("at_max15", {7'h0, amax0}, 8'h1);
    tick();
    press_up();
    expect_now("up_at_max", 4'd15, 4'd1, 1'b0, 1'b1, 1'b1, 1'b1);
    chk("wrap_at_min", {7'h0, amin1}, 8'h1);
    tick();
    expect_now("limit_one_cycle", 4'd15, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    restart = 1'b1; tick(); restart = 1'b0;
    expect_now("restart", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    press_dn();
    expect_now("dn_at_min", 4'd1, 4'd15, 1'b0, 1'b1, 1'b1, 1'b1);
    tick();

    do_load(4'd5);
    expect_now("load5", 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    up = 1'b1;
    repeat (10) tick();
    up = 1'b0;
    tick();
    expect_now("held_up", 4'd6, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0);

    do_load(4'd0);
    expect_now("load0", 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    do_load(4'd3);
    expect_now("load3", 4'd3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    clear = 1'b1; up = 1'b1; tick(); clear = 1'b0; up = 1'b0;
    expect_now("clear_with_up", 4'd0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();
    press_dn();
    expect_now("dn_at_zero", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    press_up();
    expect_now("up_from_zero", 4'd1, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    do_load(4'd15);
    tick();
    up = 1'b1; down = 1'b1; tick(); up = 1'b0; down = 1'b0;
    expect_now("both_at_max", 4'd15, 4'd15, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    up = 1'b1; do_load(4'd9); up = 1'b0;
    expect_now("load_with_up", 4'd9, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    #2 reset = 1'b1;
    #1 expect_now("async_rst", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    up = 1'b1;
    tick();
    reset = 1'b0;
    repeat (2) tick();
    expect_now("held_thru_rst", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);
    up = 1'b0;
    tick();
    press_up();
    expect_now("fresh_edge", 4'd2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/level_mem_param.md
LEVEL_MEM_PARAM -- requirements
Module: level_mem_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning level register width in bits.
REQ-002 The block SHALL have parameter LV_MIN, default 1, meaning the lowest active level and the level after reset or restart.
REQ-003 The block SHALL have parameter LV_MAX, default 2**WIDTH-1, meaning the highest active level.
REQ-004 The block SHALL have parameter WRAP, default 0, meaning 0 = saturate at LV_MAX and LV_MIN, 1 = wrap LV_MAX->LV_MIN and LV_MIN->LV_MAX.
REQ-005 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port clear, input, 1 bit: synchronous force of the level to 0 (off).
REQ-008 The block SHALL have port restart, input, 1 bit: synchronous return to LV_MIN.
REQ-009 The block SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: level to load.
REQ-011 The block SHALL have port up, input, 1 bit: level-type button; the block counts its rising edges.
REQ-012 The block SHALL have port down, input, 1 bit: level-type button; the block counts its rising edges.
REQ-013 The block SHALL have port level, output, WIDTH bits: current level.
REQ-014 The block SHALL have port at_max, output, 1 bit: high while level == LV_MAX.
REQ-015 The block SHALL have port at_min, output, 1 bit: high while level == LV_MIN.
REQ-016 The block SHALL have port changed, output, 1 bit: one-cycle pulse when level changed value in the previous cycle.
REQ-017 The block SHALL have port limit_hit, output, 1 bit: one-cycle pulse on a saturating step or a wrap.

Function
REQ-018 Parameters SHALL satisfy 1 <= LV_MIN < LV_MAX <= 2**WIDTH-1; elaboration SHALL fail otherwise.
REQ-019 An up event SHALL be the cycle after up goes from 0 to 1 while registered; a down event SHALL be defined the same way on down; a held button SHALL generate exactly one event.
REQ-020 Update priority per cycle SHALL be clear > restart > load > up/down events.
REQ-021 clear SHALL set level to 0 on the next edge.
REQ-022 restart SHALL set level to LV_MIN on the next edge.
REQ-023 load SHALL set level to load_val, clamped to LV_MIN when load_val < LV_MIN and to LV_MAX when load_val > LV_MAX; load_val 0 SHALL load 0.
REQ-024 At level 0, an up event SHALL move the level to LV_MIN and a down event SHALL have no effect.
REQ-025 An up event below LV_MAX SHALL increment the level by 1; a down event above LV_MIN SHALL decrement it by 1.
REQ-026 With WRAP=0, an up event at LV_MAX and a down event at LV_MIN SHALL leave the level unchanged and SHALL pulse limit_hit.
REQ-027 With WRAP=1, an up event at LV_MAX SHALL move the level to LV_MIN, and a down event at LV_MIN SHALL move it to LV_MAX; both SHALL pulse limit_hit.
REQ-028 Simultaneous up and down events SHALL cancel: no change and no limit_hit.
REQ-029 An up or down event coinciding with clear, restart or load SHALL be discarded.
REQ-030 changed and limit_hit SHALL be registered and asserted in the cycle after the level update, for one cycle only.
REQ-031 at_max and at_min SHALL be combinational decodes of the level register.

Reset
REQ-032 Asserting reset SHALL immediately force: level = LV_MIN, changed = 0, limit_hit = 0, edge-detector history = 1 (a button held through reset SHALL NOT produce an event).
REQ-033 reset mid-operation SHALL abort any pending event; the first event after release SHALL require a fresh 0->1 transition.

Structure
REQ-034 Shared package level_pkg SHALL hold the default WIDTH, LV_MIN and LV_MAX constants and the WRAP mode encodings.
REQ-035 Rising-edge detection SHALL be a sub-module edge_det, with reset to history 1, instantiated once for up and once for down.

Verification
REQ-036 Verification: reset with defaults -> level = 1, at_min = 1; five up pulses -> level = 6, changed pulsed 5 times.
REQ-037 Verification: WRAP=0, level 15, up pulse -> level stays 15, limit_hit is pulsed for 1 cycle, changed = 0.
REQ-038 Verification: WRAP=1, level 15, up pulse -> level = 1, limit_hit = 1 and changed = 1 for one cycle.
REQ-039 Verification: up held high for 10 cycles -> exactly one increment.
REQ-040 Verification: load with load_val 0 -> level 0; then load_val 3 -> level 3; then clear with up in the same cycle -> level 0; then down -> level 0; then up -> level 1.
REQ-041 Verification: up held across reset deassertion -> no increment until up toggles; reset pulsed mid-count at level 9 -> level = 1 asynchronously, before the next clk edge.
